inflow_scheduler: RTL and testbench

- Schedules NQ RAM buffer queues for the QSFP receive path.
- Picks which queue incoming data flows into (inflow_q) and rotates to the next free queue on a high-water mark or an idle timeout.
- Starts each queue's RAM reader once its inflow is committed.
- Serialises the readers onto the single output stream in strict fill order.
- With NQ=2 it generalises the two-queue ping-pong switch, adding timeout flushing and ordered drain.

---
 rtl/buffer_sched_pkg.sv | 10 +
 rtl/qidx_fifo.sv | 44 ++++
 rtl/inflow_scheduler.sv | 124 ++++++++++++
 tb/tb_inflow_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buffer_sched_pkg.sv
// buffer_sched_pkg: shared FSM encodings and timing constants for the queue scheduler.
package buffer_sched_pkg;

    typedef enum logic {S_FILL, S_SETTLE} in_state_t;

    typedef enum logic [1:0] {O_IDLE, O_GUARD, O_DRAIN} out_state_t;

    localparam int GUARD_CYCLES = 2;

endpackage

// File: rtl/qidx_fifo.sv
// qidx_fifo: small synchronous FIFO of queue indices recording inflow commit order.
module qidx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop & (r_cnt != '0);
    assign w_push = push & ((r_cnt != (AW+1)'(DEPTH)) | w_pop);
    assign empty  = (r_cnt == '0);
    assign head   = r_mem[r_rd];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= din;
                r_wr        <= (r_wr == AW'(DEPTH-1)) ? '0 : r_wr + AW'(1);
            end
            if (w_pop) r_rd <= (r_rd == AW'(DEPTH-1)) ? '0 : r_rd + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/inflow_scheduler.sv
// inflow_scheduler: round-robin inflow queue selection with high-water/timeout switching
// and strictly fill-ordered RAM reader draining onto one output stream.
module inflow_scheduler
    import buffer_sched_pkg::*;
#(
    parameter int NQ             = 4,
    parameter int QW             = $clog2(NQ),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic [NQ-1:0] has_data,
    input  logic [NQ-1:0] high_water,
    input  logic [NQ-1:0] inflow_done,
    input  logic [NQ-1:0] ram_reader_idle,
    output logic [QW-1:0] inflow_q,
    output logic [NQ-1:0] ram_reader_start,
    output logic [QW-1:0] outflow_q,
    output logic          outflow_active,
    output logic [31:0]   switch_count
);
    localparam int            TW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

    in_state_t     r_in_state;
    in_state_t     w_in_nxt;
    out_state_t    r_out_state;
    out_state_t    w_out_nxt;
    logic [QW-1:0] r_in_q;
    logic [QW-1:0] r_out_q;
    logic [NQ-1:0] r_busy;
    logic [NQ-1:0] r_start;
    logic          r_active;
    logic [31:0]   r_cnt;
    logic [TW-1:0] r_tmo;
    logic [1:0]    r_guard;
    logic [QW-1:0] w_next;
    logic [QW-1:0] w_head;
    logic [NQ-1:0] w_clr;
    logic [NQ-1:0] w_busy;
    logic          w_empty;
    logic          w_tmo_hit;
    logic          w_switch;
    logic          w_start;
    logic          w_drained;
    logic          w_guard_done;

    assign w_next       = (r_in_q == QW'(NQ-1)) ? '0 : r_in_q + QW'(1);
    assign w_tmo_hit    = (TIMEOUT_CYCLES != 0) && (r_tmo == TMAX);
    assign w_drained    = (r_out_state == O_DRAIN) && ram_reader_idle[r_out_q];
    // A queue finishing its drain this cycle is already free for the switch below.
    assign w_clr        = w_drained ? NQ'(1) << r_out_q : '0;
    assign w_busy       = r_busy & ~w_clr;
    assign w_switch     = (r_in_state == S_FILL) && enable && has_data[r_in_q] && !w_busy[w_next]
                          && (high_water[r_in_q] || w_tmo_hit);
    assign w_start      = (r_out_state == O_IDLE) && !w_empty && inflow_done[w_head]
                          && ram_reader_idle[w_head];
    assign w_guard_done = (r_guard == 2'(GUARD_CYCLES - 1));

    qidx_fifo #(.DEPTH(NQ), .WIDTH(QW)) u_order (
        .clk    (clk),
        .resetn (resetn),
        .push   (w_switch),
        .din    (r_in_q),
        .pop    (w_start),
        .empty  (w_empty),
        .head   (w_head)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_in_state  <= S_FILL;
            r_out_state <= O_IDLE;
        end else begin
            r_in_state  <= w_in_nxt;
            r_out_state <= w_out_nxt;
        end
    end

    always_comb begin
        w_in_nxt  = (r_in_state == S_FILL && w_switch) ? S_SETTLE : S_FILL;
        w_out_nxt = (r_out_state == O_IDLE)  ? (w_start ? O_GUARD : O_IDLE) :
                    (r_out_state == O_GUARD) ? (w_guard_done ? O_DRAIN : O_GUARD) :
                    (r_out_state == O_DRAIN && !w_drained) ? O_DRAIN : O_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_in_q   <= '0;
            r_out_q  <= '0;
            r_busy   <= '0;
            r_start  <= '0;
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_tmo    <= '0;
            r_guard  <= '0;
        end else begin
            r_busy  <= w_busy | (w_switch ? NQ'(1) << r_in_q : '0);
            r_start <= w_start ? NQ'(1) << w_head : '0;
            r_guard <= (r_out_state == O_GUARD) ? r_guard + 2'd1 : '0;
            if (w_switch) begin
                r_in_q <= w_next;
                r_cnt  <= r_cnt + 32'd1;
                r_tmo  <= '0;
            end else if (r_in_state == S_FILL && has_data[r_in_q] && r_tmo != TMAX) begin
                r_tmo <= r_tmo + TW'(1);
            end
            if (w_start) begin
                r_out_q  <= w_head;
                r_active <= 1'b1;
            end else if (w_drained) begin
                r_active <= 1'b0;
            end
        end
    end

    assign inflow_q         = r_in_q;
    assign outflow_q        = r_out_q;
    assign ram_reader_start = r_start;
    assign outflow_active   = r_active;
    assign switch_count     = r_cnt;

endmodule

// File: tb/tb_inflow_scheduler.sv
// tb_inflow_scheduler: table-driven and sequence checks of inflow_scheduler (NQ=4, timeout 16),
// with a start-strobe scoreboard holding the expected drain order.
module tb_inflow_scheduler;
    localparam int NQ = 4;
    localparam int QW = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b1;
    logic [NQ-1:0] has_data = '0;
    logic [NQ-1:0] high_water = '0;
    logic [NQ-1:0] inflow_done = '0;
    logic [NQ-1:0] ram_reader_idle = '1;
    logic [QW-1:0] inflow_q;
    logic [QW-1:0] outflow_q;
    logic [NQ-1:0] ram_reader_start;
    logic          outflow_active;
    logic [31:0]   switch_count;

    int n_vec = 0;
    int n_bad = 0;
    int sb[$];

    typedef struct {
        logic          en;
        logic [NQ-1:0] hd;
        logic [NQ-1:0] hw;
        logic [NQ-1:0] dn;
        logic [NQ-1:0] idl;
        logic [QW-1:0] e_in;
        logic [NQ-1:0] e_st;
        logic [QW-1:0] e_oq;
        logic          e_act;
        logic [31:0]   e_cnt;
    } vec_t;

    vec_t tbl[13];

    inflow_scheduler #(.NQ(NQ), .QW(QW), .TIMEOUT_CYCLES(16)) dut (
        .clk              (clk),
        .resetn           (resetn),
        .enable           (enable),
        .has_data         (has_data),
        .high_water       (high_water),
        .inflow_done      (inflow_done),
        .ram_reader_idle  (ram_reader_idle),
        .inflow_q         (inflow_q),
        .ram_reader_start (ram_reader_start),
        .outflow_q        (outflow_q),
        .outflow_active   (outflow_active),
        .switch_count     (switch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Every start strobe must match the next queue index expected in drain order.
    always @(negedge clk) begin
        int q;
        if (resetn && ram_reader_start != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_start", 32'(ram_reader_start), 32'd0);
            end else begin
                q = sb.pop_front();
                chk("sb_start", 32'(ram_reader_start), 32'(1 << q));
                chk("sb_outflow_q", 32'(outflow_q), 32'(q));
                chk("sb_active", 32'(outflow_active), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        enable = 1'b1;
        has_data = '0;
        high_water = '0;
        inflow_done = '0;
        ram_reader_idle = '1;
        sb.delete();
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic fill(input int q);
        has_data = NQ'(1) << q;
        high_water = NQ'(1) << q;
        tick();
        has_data = '0;
        high_water = '0;
        tick();
    endtask

    task automatic wait_start(input int q);
        int n = 0;
        while (ram_reader_start == '0 && n < 20) begin
            tick();
            n++;
        end
        chk("start_seen", 32'(ram_reader_start), 32'(1 << q));
    endtask

    task automatic run_reader(input int q, input int len);
        wait_start(q);
        ram_reader_idle[q] = 1'b0;
        repeat (len) begin
            tick();
            chk("start_quiet", 32'(ram_reader_start), 32'd0);
            chk("active_hold", 32'(outflow_active), 32'd1);
        end
        ram_reader_idle[q] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //              en    hd     hw     dn     idl  | in    st     oq    act   cnt
        tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 2'd0, 4'h0, 2'd0, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 4'h1, 4'h1, 4'h0, 4'hF, 2'd1, 4'h0, 2'd0, 1'b0, 32'd1};
        tbl[2]  = '{1'b1, 4'h0, 4'h0, 4'h1, 4'hF, 2'd1, 4'h1, 2'd0, 1'b1, 32'd1};
        tbl[3]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 2'd1, 4'h0, 2'd0, 1'b1, 32'd1};
        tbl[4]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 2'd1, 4'h0, 2'd0, 1'b1, 32'd1};
        tbl[5]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'hE, 2'd1, 4'h0, 2'd0, 1'b1, 32'd1};
        tbl[6]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 2'd1, 4'h0, 2'd0, 1'b0, 32'd1};
        tbl[7]  = '{1'b1, 4'h2, 4'h2, 4'h0, 4'hF, 2'd2, 4'h0, 2'd0, 1'b0, 32'd2};
        tbl[8]  = '{1'b1, 4'h4, 4'h4, 4'h0, 4'hF, 2'd2, 4'h0, 2'd0, 1'b0, 32'd2};
        tbl[9]  = '{1'b1, 4'h4, 4'h4, 4'h0, 4'hF, 2'd3, 4'h0, 2'd0, 1'b0, 32'd3};
        tbl[10] = '{1'b1, 4'h8, 4'h8, 4'h0, 4'hF, 2'd3, 4'h0, 2'd0, 1'b0, 32'd3};
        tbl[11] = '{1'b1, 4'h8, 4'h8, 4'h0, 4'hF, 2'd0, 4'h0, 2'd0, 1'b0, 32'd4};
        tbl[12] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 2'd0, 4'h0, 2'd0, 1'b0, 32'd4};

        // Basic switch, start, guard window, drain and wrap-around.
        do_reset();
        sb.push_back(0);
        for (int i = 0; i < 13; i++) begin
            enable = tbl[i].en;
            has_data = tbl[i].hd;
            high_water = tbl[i].hw;
            inflow_done = tbl[i].dn;
            ram_reader_idle = tbl[i].idl;
            tick();
            chk($sformatf("v%0d_inflow_q", i), 32'(inflow_q), 32'(tbl[i].e_in));
            chk($sformatf("v%0d_start", i), 32'(ram_reader_start), 32'(tbl[i].e_st));
            chk($sformatf("v%0d_outflow_q", i), 32'(outflow_q), 32'(tbl[i].e_oq));
            chk($sformatf("v%0d_active", i), 32'(outflow_active), 32'(tbl[i].e_act));
            chk($sformatf("v%0d_count", i), switch_count, tbl[i].e_cnt);
        end

        // Timeout: switch exactly 17 cycles after has_data rises.
        do_reset();
        fill(0);
        has_data = 4'h2;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("tmo_hold_%0d", i), 32'(inflow_q), 32'd1);
        end
        tick();
        chk("tmo_switch", 32'(inflow_q), 32'd2);
        chk("tmo_count", switch_count, 32'd2);
        has_data = '0;

        // Strict fill order despite reversed inflow_done arrival.
        do_reset();
        sb.push_back(0);
        sb.push_back(1);
        sb.push_back(2);
        fill(0);
        fill(1);
        fill(2);
        chk("ord_inflow_q", 32'(inflow_q), 32'd3);
        chk("ord_count", switch_count, 32'd3);
        inflow_done = 4'h4;
        repeat (3) begin
            tick();
            chk("ord_wait2_start", 32'(ram_reader_start), 32'd0);
        end
        inflow_done = 4'h6;
        repeat (3) begin
            tick();
            chk("ord_wait1_active", 32'(outflow_active), 32'd0);
        end
        inflow_done = 4'h7;
        run_reader(0, 4);
        run_reader(1, 2);
        run_reader(2, 3);
        tick();
        chk("ord_final_active", 32'(outflow_active), 32'd0);
        chk("ord_sb_empty", 32'(sb.size()), 32'd0);

        // All queues busy: switch blocked until busy[0] clears, then same-cycle switch.
        do_reset();
        fill(0);
        fill(1);
        fill(2);
        has_data = 4'h8;
        high_water = 4'h8;
        repeat (4) begin
            tick();
            chk("blk_inflow_q", 32'(inflow_q), 32'd3);
            chk("blk_count", switch_count, 32'd3);
        end
        sb.push_back(0);
        inflow_done = 4'h1;
        run_reader(0, 3);
        chk("blk_still3", 32'(inflow_q), 32'd3);
        tick();
        chk("blk_switch0", 32'(inflow_q), 32'd0);
        chk("blk_count4", switch_count, 32'd4);
        chk("blk_active0", 32'(outflow_active), 32'd0);
        has_data = '0;
        high_water = '0;

        // enable low: no switch, pending queue still drains.
        do_reset();
        fill(0);
        enable = 1'b0;
        has_data = 4'h2;
        high_water = 4'h2;
        repeat (3) begin
            tick();
            chk("en_hold_q", 32'(inflow_q), 32'd1);
            chk("en_hold_cnt", switch_count, 32'd1);
        end
        sb.push_back(0);
        inflow_done = 4'h1;
        run_reader(0, 2);
        tick();
        chk("en_drained", 32'(outflow_active), 32'd0);
        chk("en_still_q", 32'(inflow_q), 32'd1);
        enable = 1'b1;
        tick();
        chk("en_switch_q", 32'(inflow_q), 32'd2);
        chk("en_switch_cnt", switch_count, 32'd2);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        fill(0);
        sb.push_back(0);
        inflow_done = 4'h1;
        wait_start(0);
        ram_reader_idle[0] = 1'b0;
        tick();
        chk("rst_pre_active", 32'(outflow_active), 32'd1);
        chk("rst_pre_q", 32'(inflow_q), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_inflow_q", 32'(inflow_q), 32'd0);
        chk("rst_outflow_q", 32'(outflow_q), 32'd0);
        chk("rst_active", 32'(outflow_active), 32'd0);
        chk("rst_start", 32'(ram_reader_start), 32'd0);
        chk("rst_count", switch_count, 32'd0);
        sb.delete();
        has_data = '0;
        high_water = '0;
        inflow_done = '1;
        ram_reader_idle = '1;
        tick();
        resetn = 1'b1;
        repeat (4) begin
            tick();
            chk("rst_fifo_empty", 32'(ram_reader_start), 32'd0);
            chk("rst_post_active", 32'(outflow_active), 32'd0);
            chk("rst_post_q", 32'(inflow_q), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
